mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the microcontroller's MAR/MDR memory interface; the bus-side FSMs (instruction fetch, load/store) act as initiators.
- Samples mem_EN, mem_RW, address and write data, and inserts a programmable number of wait states.
- Performs the read or write on an internal word array.
- Completes a four-phase handshake by raising MFC and holding it until the initiator drops mem_EN.

Parameters:
- ADDR_BITS, 8, implemented address bits; array depth is 2**ADDR_BITS 16-bit words.
- WAIT_STATES, 2, idle cycles inserted between request capture and access (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- mem_EN  in  1  request strobe from initiator; level-held for the whole transaction.
- mem_RW  in  1  1 = read, 0 = write; sampled at capture.
- addr  in  16  word address from MAR.
- data_in  in  16  write data from MDR write register.
- data_out  out  16  read data to MDR read register.
- MFC  out  1  memory function complete.
- addr_err  out  1  request addressed beyond the array; valid while MFC=1.

Behaviour:
- Reset: clk edge with rst=0 forces the following; array contents are unaffected.
  - state=IDLE
  - MFC=0, addr_err=0, data_out=16'h0000
  - wait counter=0
- States:
  - IDLE
  - BUSY: wait counting.
  - DONE: MFC held.
- IDLE:
  - At edge N with mem_EN=1, capture addr, mem_RW and data_in into internal registers.
  - Load counter with WAIT_STATES and go to BUSY.
  - Input changes after edge N are ignored.
- BUSY, counter>0: decrement the counter.
- BUSY, counter==0, at that edge:
  - Perform the access.
  - Read: data_out <= array[addr].
  - Write: array[addr] <= data_in; data_out unchanged.
  - Set MFC=1 and go to DONE.
- Latency: MFC rises at edge N+1+WAIT_STATES. With WAIT_STATES=0 it rises at edge N+1.
- DONE:
  - MFC and data_out are held while mem_EN=1; no second access occurs.
  - First edge with mem_EN=0: MFC<=0, addr_err<=0, go to IDLE.
  - data_out retains its value until the next read completes.
- Back-to-back: the earliest new capture is the edge after returning to IDLE. MFC is therefore low for at least one cycle between transactions.
- Abort: mem_EN=0 sampled in BUSY returns to IDLE immediately. No write is committed, data_out is unchanged and MFC never rises.
- Out of range (captured addr[15:ADDR_BITS] != 0):
  - Access completes with normal latency; addr_err=1 with MFC.
  - Read returns data_out=16'h0000.
  - Write is dropped.
- Reset mid-transaction: returns to IDLE and drops MFC at that edge. A pending write is not committed.
- Array is never driven onto the shared bus. Tri-stating of data_out remains the MDR's job.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - RW encodings: MEM_READ=1'b1, MEM_WRITE=1'b0.
  - default ADDR_BITS and WAIT_STATES.
- Sub-module mem_array:
  - single-port synchronous 16-bit RAM with we, addr, wdata, rdata.
  - registered read.
  - instantiated once.
- Handshake FSM, counter and range check live in mem_responder.

Test Plan:
- Reset, then write/read: write 16'hBEEF to addr 16'h0005, then read 16'h0005.
  - Both accesses: MFC rises exactly 3 edges after capture (WAIT_STATES=2).
  - Read returns data_out=16'hBEEF, addr_err=0.
- Handshake hold: keep mem_EN=1 for 6 cycles after MFC.
  - MFC stays 1 and data_out stays stable.
  - A pre-placed marker value at another address is unchanged (no repeat access).
  - MFC falls on the first edge with mem_EN=0.
- Abort: issue write 16'h1234 to addr 16'h0007, drop mem_EN one cycle after capture.
  - MFC never asserts.
  - A subsequent read of 16'h0007 returns the prior value.
- Out of range: read addr 16'h0100 with ADDR_BITS=8.
  - MFC after 3 edges, addr_err=1, data_out=16'h0000.
  - A write of 16'hAAAA to 16'h0100 leaves addr 16'h0000 unchanged.
- Input change after capture: change addr and data_in during BUSY.
  - Originally captured address and data are written.
- Reset mid-BUSY: rst=0 for one edge during a write of 16'h5555 to 16'h0009.
  - MFC=0 and data_out=16'h0000 after that edge.
  - Addr 16'h0009 is unchanged; the array is otherwise intact.
- Repeat with WAIT_STATES=0: MFC rises exactly 1 edge after capture.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared encodings and defaults for the MAR/MDR memory responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  localparam int DEF_ADDR_BITS   = 8;
  localparam int DEF_WAIT_STATES = 2;

  // True when any address bit above the implemented range is set.
  function automatic logic out_of_range(input logic [15:0] a, input int bits);
    return (32'(a) >> bits) != 32'd0;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Initiator/responder bus bundle for the MAR/MDR memory interface.
interface mem_responder_if;
  logic        mem_EN;
  logic        mem_RW;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        MFC;
  logic        addr_err;

  modport master (
    output mem_EN, mem_RW, addr, data_in,
    input  data_out, MFC, addr_err
  );

  modport slave (
    input  mem_EN, mem_RW, addr, data_in,
    output data_out, MFC, addr_err
  );
endinterface

// File: rtl/mem_responder_array.sv
// Single-port 16-bit word RAM with a registered read port.
module mem_array #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);

  logic [15:0] mem [2**ADDR_BITS];
  logic [15:0] rdata_reg;

  // Write-first is not needed: the read returns the old word on a write cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: captures a request, waits WAIT_STATES cycles, performs
// the access and holds MFC until the initiator releases mem_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  state_t                state_reg;
  logic [3:0]            cnt_reg;
  logic [15:0]           addr_cap_reg;
  logic [15:0]           data_cap_reg;
  logic                  rw_cap_reg;
  logic [15:0]           data_out_reg;
  logic                  mfc_reg;
  logic                  addr_err_reg;

  logic                  oor;
  logic                  access_now;
  logic                  ram_we;
  logic [ADDR_BITS-1:0]  ram_addr;
  logic [15:0]           ram_rdata;

  assign oor = out_of_range(addr_cap_reg, ADDR_BITS);

  // The access edge: still requested, counter exhausted. Abort and reset win.
  assign access_now = rst && (state_reg == BUSY) && bus.mem_EN && (cnt_reg == 4'd0);
  assign ram_we     = access_now && (rw_cap_reg == MEM_WRITE) && !oor;

  // In IDLE the RAM is addressed straight from the bus so the registered read
  // is already valid when a zero-wait access completes one edge later.
  assign ram_addr = (state_reg == IDLE) ? bus.addr[ADDR_BITS-1:0]
                                        : addr_cap_reg[ADDR_BITS-1:0];

  mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data_cap_reg),
    .rdata (ram_rdata)
  );

  // Handshake FSM with wait counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      mfc_reg      <= 1'b0;
      addr_err_reg <= 1'b0;
      data_out_reg <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.mem_EN) begin
            addr_cap_reg <= bus.addr;
            data_cap_reg <= bus.data_in;
            rw_cap_reg   <= bus.mem_RW;
            cnt_reg      <= 4'(WAIT_STATES);
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.mem_EN) begin
            state_reg <= IDLE;
          end else if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            mfc_reg      <= 1'b1;
            addr_err_reg <= oor;
            if (rw_cap_reg == MEM_READ) begin
              data_out_reg <= oor ? 16'h0000 : ram_rdata;
            end
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (!bus.mem_EN) begin
            mfc_reg      <= 1'b0;
            addr_err_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.data_out = data_out_reg;
  assign bus.MFC      = mfc_reg;
  assign bus.addr_err = addr_err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one 2-wait-state instance and one
// zero-wait-state instance sharing clock and reset.
module tb_mem_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_responder_if b0 ();
  mem_responder_if b1 ();

  mem_responder #(.ADDR_BITS(8), .WAIT_STATES(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transaction on the 2-wait-state instance. If scramble is set, the
  // bus address/data are changed right after capture (and stay changed
  // during the hold) to prove they are ignored.
  task automatic xact(input logic rw, input logic [15:0] a, input logic [15:0] d,
                      input int hold, input bit scramble,
                      input logic [15:0] exp_d, input logic exp_err, input string tag);
    b0.mem_EN  = 1'b1;
    b0.mem_RW  = rw;
    b0.addr    = a;
    b0.data_in = d;
    step();
    if (scramble) begin
      b0.addr    = 16'h0003;
      b0.data_in = 16'h9999;
    end
    chk({tag, "_mfc_capture"}, 32'(b0.MFC), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk({tag, "_mfc_wait"}, 32'(b0.MFC), 32'd0);
    end
    step();
    chk({tag, "_mfc_rise"}, 32'(b0.MFC), 32'd1);
    chk({tag, "_addr_err"}, 32'(b0.addr_err), 32'(exp_err));
    chk({tag, "_data_out"}, 32'(b0.data_out), 32'(exp_d));
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_mfc_hold"}, 32'(b0.MFC), 32'd1);
      chk({tag, "_data_hold"}, 32'(b0.data_out), 32'(exp_d));
    end
    b0.mem_EN = 1'b0;
    step();
    chk({tag, "_mfc_fall"}, 32'(b0.MFC), 32'd0);
    chk({tag, "_err_fall"}, 32'(b0.addr_err), 32'd0);
    chk({tag, "_data_keep"}, 32'(b0.data_out), 32'(exp_d));
    $display("xact %s rw=%0b addr=%h wdata=%h data_out=%h", tag, rw, a, d, b0.data_out);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    b0.mem_EN = 1'b0; b0.mem_RW = 1'b0; b0.addr = 16'h0; b0.data_in = 16'h0;
    b1.mem_EN = 1'b0; b1.mem_RW = 1'b0; b1.addr = 16'h0; b1.data_in = 16'h0;

    // Reset
    step();
    step();
    chk("rst_mfc", 32'(b0.MFC), 32'd0);
    chk("rst_err", 32'(b0.addr_err), 32'd0);
    chk("rst_dout", 32'(b0.data_out), 32'd0);
    chk("rst_mfc1", 32'(b1.MFC), 32'd0);
    rst = 1'b1;
    step();

    // Write then read back
    xact(1'b0, 16'h0005, 16'hBEEF, 0, 1'b0, 16'h0000, 1'b0, "wr5");
    xact(1'b1, 16'h0005, 16'h0000, 0, 1'b0, 16'hBEEF, 1'b0, "rd5");

    // Preload markers
    xact(1'b0, 16'h0003, 16'h1111, 0, 1'b0, 16'hBEEF, 1'b0, "wr3");
    xact(1'b0, 16'h0007, 16'h7777, 0, 1'b0, 16'hBEEF, 1'b0, "wr7");
    xact(1'b0, 16'h0009, 16'h9090, 0, 1'b0, 16'hBEEF, 1'b0, "wr9");
    xact(1'b0, 16'h0000, 16'h4444, 0, 1'b0, 16'hBEEF, 1'b0, "wr0");

    // Handshake hold for 6 cycles; a repeat access would hit marker at 3
    xact(1'b0, 16'h0006, 16'h2222, 6, 1'b1, 16'hBEEF, 1'b0, "hold");
    xact(1'b1, 16'h0003, 16'h0000, 0, 1'b0, 16'h1111, 1'b0, "rd3");
    xact(1'b1, 16'h0006, 16'h0000, 0, 1'b0, 16'h2222, 1'b0, "rd6");

    // Abort one cycle after capture
    b0.mem_EN = 1'b1; b0.mem_RW = 1'b0; b0.addr = 16'h0007; b0.data_in = 16'h1234;
    step();
    b0.mem_EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_mfc", 32'(b0.MFC), 32'd0);
    end
    $display("xact abort rw=0 addr=0007 wdata=1234 data_out=%h", b0.data_out);
    xact(1'b1, 16'h0007, 16'h0000, 0, 1'b0, 16'h7777, 1'b0, "rd7_abort");

    // Out of range
    xact(1'b1, 16'h0100, 16'h0000, 0, 1'b0, 16'h0000, 1'b1, "oor_rd");
    xact(1'b0, 16'h0100, 16'hAAAA, 0, 1'b0, 16'h0000, 1'b1, "oor_wr");
    xact(1'b1, 16'h0000, 16'h0000, 0, 1'b0, 16'h4444, 1'b0, "rd0");

    // Inputs changed during BUSY
    xact(1'b0, 16'h0008, 16'h3333, 0, 1'b1, 16'h4444, 1'b0, "chg_wr8");
    xact(1'b1, 16'h0008, 16'h0000, 0, 1'b0, 16'h3333, 1'b0, "rd8");
    xact(1'b1, 16'h0003, 16'h0000, 0, 1'b0, 16'h1111, 1'b0, "rd3_chg");

    // Reset in the middle of BUSY
    b0.mem_EN = 1'b1; b0.mem_RW = 1'b0; b0.addr = 16'h0009; b0.data_in = 16'h5555;
    step();
    step();
    rst = 1'b0;
    step();
    chk("midrst_mfc", 32'(b0.MFC), 32'd0);
    chk("midrst_dout", 32'(b0.data_out), 32'd0);
    rst = 1'b1;
    b0.mem_EN = 1'b0;
    step();
    chk("midrst_mfc_after", 32'(b0.MFC), 32'd0);
    $display("xact midrst rw=0 addr=0009 wdata=5555 data_out=%h", b0.data_out);
    xact(1'b1, 16'h0009, 16'h0000, 0, 1'b0, 16'h9090, 1'b0, "rd9_rst");
    xact(1'b1, 16'h0008, 16'h0000, 0, 1'b0, 16'h3333, 1'b0, "rd8_rst");

    // Zero wait states
    b1.mem_EN = 1'b1; b1.mem_RW = 1'b0; b1.addr = 16'h0004; b1.data_in = 16'hC0DE;
    step();
    chk("ws0_wr_capture", 32'(b1.MFC), 32'd0);
    step();
    chk("ws0_wr_mfc", 32'(b1.MFC), 32'd1);
    chk("ws0_wr_err", 32'(b1.addr_err), 32'd0);
    chk("ws0_wr_dout", 32'(b1.data_out), 32'd0);
    b1.mem_EN = 1'b0;
    step();
    chk("ws0_wr_fall", 32'(b1.MFC), 32'd0);
    $display("xact ws0_wr rw=0 addr=0004 wdata=c0de data_out=%h", b1.data_out);
    b1.mem_EN = 1'b1; b1.mem_RW = 1'b1;
    step();
    chk("ws0_rd_capture", 32'(b1.MFC), 32'd0);
    step();
    chk("ws0_rd_mfc", 32'(b1.MFC), 32'd1);
    chk("ws0_rd_dout", 32'(b1.data_out), 32'h0000C0DE);
    b1.mem_EN = 1'b0;
    step();
    chk("ws0_rd_fall", 32'(b1.MFC), 32'd0);
    $display("xact ws0_rd rw=1 addr=0004 data_out=%h", b1.data_out);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
